// File: rtl/agc_out_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : agc_out_quantizer
//  Description : Requantizes the AGC output (sfix39_En36) to sfix16_En13 with
//                rounding and saturation. Also keeps a windowed peak magnitude,
//                a saturation-event counter and a sticky saturation flag.
//                Optional macro AGC_OUT_CONVERGENT_EN selects convergent
//                (ties-to-even) rounding instead of round-half-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_out_quantizer #(
    parameter int IN_W     = 39,
    parameter int IN_FRAC  = 36,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 13,
    parameter int WIN_LEN  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [IN_W-1:0]  in_agc,
    input  logic             clear_stats,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    output logic [OUT_W-1:0] peak_mag,
    output logic             peak_valid,
    output logic [CNT_W-1:0] sat_count,
    output logic             sat_flag
);

    localparam int c_SHIFT  = IN_FRAC - OUT_FRAC;
    localparam int c_S1_W   = IN_W + 1 - c_SHIFT;
    localparam int c_WCNT_W = $clog2(WIN_LEN);
    localparam logic [c_WCNT_W-1:0] c_WLAST = c_WCNT_W'(WIN_LEN - 1);

    // Stage-1 rounding: widen by one bit so the rounding add cannot overflow
    logic [IN_W:0]      w_ext;
    logic [IN_W:0]      w_bias;
    logic [IN_W:0]      w_rnd;
    logic [c_S1_W-1:0]  w_s1;
    logic               w_unused;

    assign w_ext = {in_agc[IN_W-1], in_agc};

`ifdef AGC_OUT_CONVERGENT_EN
    // Half-LSB minus one plus the kept LSB: a tie carries only when the kept
    // part is odd, so ties land on the even neighbour.
    localparam logic [IN_W:0] c_HALF_M1 = {{(IN_W + 2 - c_SHIFT){1'b0}}, {(c_SHIFT - 1){1'b1}}};
    assign w_bias = c_HALF_M1 + {{IN_W{1'b0}}, in_agc[c_SHIFT]};
`else
    localparam logic [IN_W:0] c_HALF = {{(IN_W + 1 - c_SHIFT){1'b0}}, 1'b1, {(c_SHIFT - 1){1'b0}}};
    assign w_bias = c_HALF;
`endif

    assign w_rnd    = w_ext + w_bias;
    assign w_s1     = w_rnd[IN_W:c_SHIFT];
    // Discarded fraction bits only feed the carry; they are not needed further
    assign w_unused = ^w_rnd[c_SHIFT-1:0];

    // Stage-1 registers
    logic [c_S1_W-1:0]  r_s1;
    logic               r_v1;

    // Capture the rounded value on every enabled edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_v1 <= 1'b0;
        end else if (clk_enable) begin
            r_s1 <= w_s1;
            r_v1 <= 1'b1;
        end
    end

    // Stage-2 saturation: in range when all bits above the output sign agree
    logic [c_S1_W-OUT_W:0] w_hi;
    logic                  w_ovf;
    logic [OUT_W-1:0]      w_q;
    logic [OUT_W-1:0]      w_mag;
    logic                  w_fire;

    assign w_hi   = r_s1[c_S1_W-1:OUT_W-1];
    assign w_ovf  = !((&w_hi) | ~(|w_hi));
    assign w_q    = !w_ovf            ? r_s1[OUT_W-1:0] :
                    r_s1[c_S1_W-1]    ? {1'b1, {(OUT_W - 1){1'b0}}} :
                                        {1'b0, {(OUT_W - 1){1'b1}}};
    // Two's-complement negate in OUT_W bits keeps |0x8000| = 0x8000
    assign w_mag  = w_q[OUT_W-1] ? (~w_q + OUT_W'(1)) : w_q;
    assign w_fire = clk_enable & r_v1;

    logic [OUT_W-1:0]    r_out_q;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_peak_mag;
    logic                r_peak_valid;
    logic [OUT_W-1:0]    r_run_max;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]    r_sat_cnt;
    logic                r_sat_flag;
    logic [OUT_W-1:0]    w_max;

    assign w_max = (w_mag > r_run_max) ? w_mag : r_run_max;

    // Output register and its one-cycle valid pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_fire;
            if (w_fire) begin
                r_out_q <= w_q;
            end
        end
    end

    // Statistics: peak window and saturation tracking; clear wins over updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak_mag   <= '0;
            r_peak_valid <= 1'b0;
            r_run_max    <= '0;
            r_wcnt       <= '0;
            r_sat_cnt    <= '0;
            r_sat_flag   <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (clk_enable) begin
                if (clear_stats) begin
                    r_run_max  <= '0;
                    r_wcnt     <= '0;
                    r_sat_cnt  <= '0;
                    r_sat_flag <= 1'b0;
                end else if (r_v1) begin
                    if (w_ovf) begin
                        r_sat_flag <= 1'b1;
                        if (r_sat_cnt != {CNT_W{1'b1}}) begin
                            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
                        end
                    end
                    if (r_wcnt == c_WLAST) begin
                        r_peak_mag   <= w_max;
                        r_peak_valid <= 1'b1;
                        r_run_max    <= '0;
                        r_wcnt       <= '0;
                    end else begin
                        r_run_max    <= w_max;
                        r_wcnt       <= r_wcnt + c_WCNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_q      = r_out_q;
    assign out_valid  = r_out_valid;
    assign peak_mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
    assign sat_count  = r_sat_cnt;
    assign sat_flag   = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_agc_out_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agc_out_quantizer
//  Description : Self-checking bench for agc_out_quantizer (WIN_LEN=4,
//                CNT_W=2) with a real-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agc_out_quantizer;

    localparam int IN_W    = 39;
    localparam int OUT_W   = 16;
    localparam int WIN_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clk_enable = 1'b0;
    logic              clear_stats = 1'b0;
    logic [IN_W-1:0]   in_agc = '0;
    logic [OUT_W-1:0]  out_q;
    logic              out_valid;
    logic [OUT_W-1:0]  peak_mag;
    logic              peak_valid;
    logic [CNT_W-1:0]  sat_count;
    logic              sat_flag;

    agc_out_quantizer #(
        .IN_W(39), .IN_FRAC(36), .OUT_W(16), .OUT_FRAC(13),
        .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_agc(in_agc),
        .clear_stats(clear_stats), .out_q(out_q), .out_valid(out_valid),
        .peak_mag(peak_mag), .peak_valid(peak_valid),
        .sat_count(sat_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_v1;
    int          m_s1;
    logic [15:0] m_q;
    bit          m_ov;
    bit          m_pv;
    logic [15:0] m_pk;
    int          m_cnt;
    bit          m_flag;
    int          win[$];

    // Ideal rounding of the real input value to an integer count of 2^-13
    function automatic int round_in(logic [IN_W-1:0] x);
        longint v;
        real    r, fl, fr;
        int     q;
        v  = longint'($signed(x));
        r  = real'(v) / 8388608.0;
        fl = $floor(r);
        fr = r - fl;
        q  = $rtoi(fl);
`ifdef AGC_OUT_CONVERGENT_EN
        if (fr > 0.5 || (fr == 0.5 && (q % 2) != 0)) q = q + 1;
`else
        if (fr >= 0.5) q = q + 1;
`endif
        return q;
    endfunction

    task automatic model_reset();
        m_v1 = 0; m_s1 = 0; m_q = '0; m_ov = 0; m_pv = 0;
        m_pk = '0; m_cnt = 0; m_flag = 0; win.delete();
    endtask

    task automatic model_edge(bit en, logic [IN_W-1:0] x, bit clr);
        int  c, mag, mx;
        bit  sat;
        m_ov = 0;
        m_pv = 0;
        if (!en) return;
        if (clr) begin
            m_cnt = 0; m_flag = 0; win.delete();
        end
        if (m_v1) begin
            sat = (m_s1 > 32767) || (m_s1 < -32768);
            c   = (m_s1 > 32767) ? 32767 : (m_s1 < -32768) ? -32768 : m_s1;
            m_q  = c[15:0];
            m_ov = 1;
            mag  = (c < 0) ? -c : c;
            if (!clr) begin
                if (sat) begin
                    m_flag = 1;
                    if (m_cnt < SAT_MAX) m_cnt++;
                end
                win.push_back(mag);
                if (win.size() == WIN_LEN) begin
                    mx = 0;
                    foreach (win[i]) if (win[i] > mx) mx = win[i];
                    m_pk = mx[15:0];
                    m_pv = 1;
                    win.delete();
                end
            end
        end
        m_s1 = round_in(x);
        m_v1 = 1;
    endtask

    task automatic check(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".out_q"},      longint'(out_q),      longint'(m_q));
        check({tag, ".out_valid"},  longint'(out_valid),  longint'(m_ov));
        check({tag, ".peak_mag"},   longint'(peak_mag),   longint'(m_pk));
        check({tag, ".peak_valid"}, longint'(peak_valid), longint'(m_pv));
        check({tag, ".sat_count"},  longint'(sat_count),  longint'(m_cnt));
        check({tag, ".sat_flag"},   longint'(sat_flag),   longint'(m_flag));
    endtask

    task automatic step(bit en, logic [IN_W-1:0] x, bit clr, string tag);
        clk_enable  = en;
        in_agc      = x;
        clear_stats = clr;
        @(posedge clk);
        model_edge(en, x, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [63:0]     r64;
        logic [IN_W-1:0] x;
        logic [15:0]     held;
        int              tie_exp;

        // Reset state
        model_reset();
        #2;
        check_all("reset");
        #10 reset = 1'b1;

        // Basic +1.0
        step(1, 39'h10_0000_0000, 0, "basic1");
        check("basic_first_valid", longint'(out_valid), 0);
        step(1, 39'h0, 0, "basic2");
        check("basic_out", longint'(out_q), 64'h2000);
        check("basic_valid", longint'(out_valid), 1);

        // Rounding ties
`ifdef AGC_OUT_CONVERGENT_EN
        tie_exp = 0;
`else
        tie_exp = 1;
`endif
        step(1, 39'h00_0040_0000, 0, "tie_a_in");
        step(1, 39'h00_00C0_0000, 0, "tie_b_in");
        check("tie_half", longint'(out_q), longint'(tie_exp));
        step(1, 39'h7F_FFC0_0000, 0, "tie_c_in");
        check("tie_1p5", longint'(out_q), 64'h0002);
        step(1, 39'h0, 0, "tie_d");
        check("tie_neg_half", longint'(out_q), 64'h0000);

        // Saturation
        step(1, 39'h0, 1, "sat_clr");
        step(1, 39'h3F_FFFF_FFFF, 0, "sat_in1");
        step(1, 39'h40_0000_0000, 0, "sat_in2");
        check("sat_pos_out", longint'(out_q), 64'h7FFF);
        check("sat_pos_cnt", longint'(sat_count), 1);
        check("sat_pos_flag", longint'(sat_flag), 1);
        step(1, 39'h0, 0, "sat_in3");
        check("neg4_out", longint'(out_q), 64'h8000);
        check("neg4_cnt", longint'(sat_count), 1);

        // Peak windows of four
        step(1, 39'h10_0000_0000, 1, "pk_clr");
        step(1, 39'h68_0000_0000, 0, "pk1");
        step(1, 39'h08_0000_0000, 0, "pk2");
        check("pk_neg_out", longint'(out_q), 64'hD000);
        step(1, 39'h04_0000_0000, 0, "pk3");
        step(1, 39'h00_8000_0000, 0, "pk4");
        check("pk_w1_valid", longint'(peak_valid), 1);
        check("pk_w1_mag", longint'(peak_mag), 64'h3000);
        for (int i = 0; i < 3; i++) step(1, 39'h00_8000_0000, 0, "pk_w2");
        check("pk_hold_mag", longint'(peak_mag), 64'h3000);
        step(1, 39'h0, 0, "pk_w2_end");
        check("pk_w2_valid", longint'(peak_valid), 1);
        check("pk_w2_mag", longint'(peak_mag), 64'h0100);

        // Enable gap
        step(1, 39'h08_0000_0000, 0, "gap_pre");
        held = out_q;
        for (int i = 0; i < 3; i++) begin
            step(0, 39'h3F_FFFF_FFFF, 1, "gap");
            check("gap_no_valid", longint'(out_valid), 0);
            check("gap_held", longint'(out_q), longint'(held));
        end
        step(1, 39'h0, 0, "gap_post");
        check("gap_resume", longint'(out_q), 64'h1000);

        // Clear coinciding with a saturating output
        step(1, 39'h3F_FFFF_FFFF, 0, "clrsat_in");
        step(1, 39'h0, 1, "clrsat");
        check("clrsat_out", longint'(out_q), 64'h7FFF);
        check("clrsat_cnt", longint'(sat_count), 0);
        check("clrsat_flag", longint'(sat_flag), 0);

        // Counter sticks at all-ones
        for (int i = 0; i < 5; i++) step(1, 39'h3F_FFFF_FFFF, 0, "cnt_sat");
        step(1, 39'h0, 0, "cnt_end");
        check("cnt_stick", longint'(sat_count), 3);

        // Reset asserted between edges
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        #2 reset = 1'b1;
        step(1, 39'h10_0000_0000, 0, "rst_e1");
        check("rst_e1_valid", longint'(out_valid), 0);
        step(1, 39'h0, 0, "rst_e2");
        check("rst_e2_valid", longint'(out_valid), 1);
        check("rst_e2_out", longint'(out_q), 64'h2000);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: x = r64[IN_W-1:0];
                1: x = 39'h3F_FFFF_FFFF - {16'h0, r64[22:0]};
                2: x = {r64[38:23], 23'h40_0000};
                3: x = 39'h40_0000_0000 + {16'h0, r64[22:0]};
                default: x = {{13{r64[25]}}, r64[25:0]};
            endcase
            step(($urandom_range(0, 3) != 0), x, ($urandom_range(0, 49) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
